mx_fp32_stim_gen: RTL and testbench
===================================

MX_FP32_STIM_GEN -- requirements
Module: mx_fp32_stim_gen

Interface
REQ-001 SHALL have parameter LANES, default 4: FP32 elements per output beat; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter BLOCK_SIZE, default 32: elements per MX block; it SHALL be a multiple of LANES.
REQ-003 SHALL have parameter ELEM_MBITS, default 6: explicit magnitude bits kept by MXINT8; TRUNC = 23-ELEM_MBITS.
REQ-004 clk  input  1  single clock; all logic rises on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start_i  input  1  launch a run; accepted only in IDLE.
REQ-007 abort_i  input  1  cancel the run in progress.
REQ-008 mode_i  input  3  scenario: NORMAL, CARRY, TIE, MANT_OVF, SCALE_OVF, NAN, SUBNORM; sampled on start.
REQ-009 sign_mode_i  input  2  POS, NEG, ALT (per block, first block positive), RAND; sampled on start.
REQ-010 num_blocks_i  input  16  blocks to emit; sampled on start.
REQ-011 seed_i  input  32  LFSR seed; sampled on start.
REQ-012 data_o  output  32*LANES  FP32 elements; lane 0 in the LSBs.
REQ-013 valid_o / ready_i  output / input  1 / 1  beat handshake.
REQ-014 last_o  output  1  marks the final beat of a block.
REQ-015 busy_o / done_o  output / output  1 / 1  run active / one-cycle completion pulse.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, RUN, DONE; DONE SHALL last one cycle and return to IDLE.
REQ-017 start_i in IDLE at cycle t SHALL give LOAD at t+1, RUN with valid_o=1 at t+2; start_i outside IDLE SHALL be ignored.
REQ-018 num_blocks_i=0 SHALL go IDLE->LOAD->DONE, emitting no beat, with done_o pulsed.
REQ-019 Each lane SHALL own a 32-bit Galois LFSR, taps 0x80200003, seeded seed_i ^ (lane*0x9E3779B9); a resulting seed of 0 SHALL be replaced by 1.
REQ-020 LFSRs SHALL step once only on accepted beats (valid_o&&ready_i) and once in LOAD; data_o SHALL hold stable while valid_o&&!ready_i.
REQ-021 A beat counter SHALL count 0..BLOCK_SIZE/LANES-1; last_o SHALL be asserted at terminal count; a block counter SHALL increment on each accepted last beat.
REQ-022 Acceptance of the last beat of block num_blocks-1 SHALL drop valid_o in the next cycle and enter DONE.
REQ-023 A block exponent in [2,253] SHALL be drawn from the lane 0 LFSR at LOAD and at each block boundary; all non-NORMAL elements in that block SHALL use it.
REQ-024 NORMAL: exp = LFSR[30:23] clamped to [1,254]; mantissa = LFSR[22:0].
REQ-025 CARRY: guard bit mant[TRUNC-1]=1; sticky bits nonzero (bit 0 forced to 1); mant[22:TRUNC] random, but not all ones.
REQ-026 TIE: guard=1; sticky bits=0; mant[TRUNC] random, so both even and odd ties occur.
REQ-027 MANT_OVF: mant[22:TRUNC] all ones; guard=1; sticky nonzero.
REQ-028 SCALE_OVF: MANT_OVF pattern with exp=254.
REQ-029 NAN: exp=255; mant[22]=1; rest random.
REQ-030 SUBNORM: exp=0; mant random, with bit 0 forced to 1 so the value is nonzero.
REQ-031 Sign: POS=0; NEG=1; ALT = block index LSB; RAND = LFSR[31] per lane.
REQ-032 abort_i SHALL force IDLE on the next cycle, with valid_o=0 and no done_o pulse; abort SHALL take priority over an accepted beat in the same cycle.
REQ-033 busy_o SHALL be 1 in LOAD and RUN.

Reset
REQ-034 rst SHALL force IDLE; data_o, valid_o, last_o, busy_o and done_o SHALL all be 0; counters and LFSRs SHALL be 0.
REQ-035 rst SHALL override start_i and abort_i, including when asserted mid-run.

Structure
REQ-036 Package mx_stim_pkg SHALL hold: the mode and sign_mode enums, FP32 field widths, the default ELEM_MBITS, the LFSR taps, and the lane seed constant.
REQ-037 Sub-module mx_lfsr32 (load, step, seed, state) SHALL be instantiated once per lane.
REQ-038 Field shaping SHALL be combinational from the LFSR state, with data_o registered.

Verification
REQ-039 LANES=4, NORMAL, POS, num_blocks=2, ready_i=1: exactly 16 beats; last_o on beats 8 and 16; done_o 1 cycle after the final accept; every exp in [1,254]; every sign 0.
REQ-040 TIE with ELEM_MBITS=6: every element has mant[16]=1 and mant[15:0]=0; ALT gives signs 0 for block 0 and 1 for block 1.
REQ-041 SCALE_OVF: every element has exp=0xFE and mant[22:16] all ones; the reference model shows the MXINT8 scale carries to NaN.
REQ-042 Drive ready_i with a 50% random pattern: data_o stable while stalled; the sequence matches the ready_i=1 run with the same seed.
REQ-043 seed_i=0: LFSRs load 1; the output is identical to seed_i=1 for lane 0.
REQ-044 abort_i at beat 5 and rst at beat 3 of a new run: valid_o=0 next cycle, no done_o, FSM in IDLE; a fresh start_i then runs correctly.

Source files
------------

// File: rtl/mx_stim_pkg.sv
// Shared types and constants for the MX FP32 stimulus generator.
// Scenario/sign enums, FP32 field widths, LFSR taps and lane seed spreading.
package mx_stim_pkg;

  typedef enum logic [2:0] {
    ModeNormal   = 3'd0,
    ModeCarry    = 3'd1,
    ModeTie      = 3'd2,
    ModeMantOvf  = 3'd3,
    ModeScaleOvf = 3'd4,
    ModeNan      = 3'd5,
    ModeSubnorm  = 3'd6
  } mode_e;

  typedef enum logic [1:0] {
    SignPos  = 2'd0,
    SignNeg  = 2'd1,
    SignAlt  = 2'd2,
    SignRand = 2'd3
  } sign_mode_e;

  localparam int unsigned ExpW             = 8;
  localparam int unsigned ManW             = 23;
  localparam int unsigned DefaultElemMbits = 6;

  localparam logic [31:0] LfsrTaps    = 32'h8020_0003;
  localparam logic [31:0] LaneSeedInc = 32'h9E37_79B9;

  localparam logic [ExpW-1:0] BlkExpMin   = 8'd2;
  localparam logic [ExpW-1:0] BlkExpMax   = 8'd253;
  localparam logic [ExpW-1:0] NormExpMin  = 8'd1;
  localparam logic [ExpW-1:0] NormExpMax  = 8'd254;
  localparam logic [ExpW-1:0] ScaleOvfExp = 8'd254;
  localparam logic [ExpW-1:0] NanExp      = 8'd255;

  function automatic logic [ExpW-1:0] clamp_exp(logic [ExpW-1:0] v, logic [ExpW-1:0] lo,
                                                logic [ExpW-1:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/mx_lfsr32.sv
// 32-bit Galois LFSR (right-shifting) with synchronous load; a zero seed loads 1
// so the register can never lock up in the all-zero state.
module mx_lfsr32
  import mx_stim_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == 32'd0) ? 32'd1 : seed;
    end else if (step) begin
      state_d = state_q[0] ? ((state_q >> 1) ^ LfsrTaps) : (state_q >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= 32'd0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/mx_fp32_stim_gen.sv
// FP32 stimulus generator for MX (shared-exponent) quantiser verification: emits blocks of
// FP32 elements shaped to hit rounding corner cases, LANES elements per valid/ready beat.
module mx_fp32_stim_gen
  import mx_stim_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned BLOCK_SIZE = 32,
  parameter int unsigned ELEM_MBITS = DefaultElemMbits
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [2:0]            mode_i,
  input  logic [1:0]            sign_mode_i,
  input  logic [15:0]           num_blocks_i,
  input  logic [31:0]           seed_i,
  output logic [32*LANES-1:0]   data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned BeatsPerBlock = BLOCK_SIZE / LANES;
  localparam int unsigned BeatW         = (BeatsPerBlock > 1) ? $clog2(BeatsPerBlock) : 1;
  localparam int unsigned Trunc         = ManW - ELEM_MBITS;

  localparam logic [BeatW-1:0] BeatLast   = BeatW'(BeatsPerBlock - 1);
  localparam logic [ManW-1:0]  KeepMask   = ManW'(((32'd1 << ELEM_MBITS) - 32'd1) << Trunc);
  localparam logic [ManW-1:0]  KeepLsb    = ManW'(32'd1 << Trunc);
  localparam logic [ManW-1:0]  GuardBit   = ManW'(32'd1 << (Trunc - 1));

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e                state_q, state_d;
  mode_e                 mode_q;
  sign_mode_e            sign_q;
  logic [15:0]           num_blocks_q;
  logic [BeatW-1:0]      beat_q, beat_d;
  logic [15:0]           blk_q, blk_d;
  logic [ExpW-1:0]       blk_exp_q, blk_exp_d;
  logic                  valid_q, valid_d;
  logic [32*LANES-1:0]   data_q, data_d;
  logic                  lfsr_load, lfsr_step, new_block;
  logic                  accept, beat_is_last, final_beat;
  logic [31:0]           lfsr_state [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam logic [31:0] LaneSeed = 32'(32'(l) * LaneSeedInc);
    mx_lfsr32 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load  (lfsr_load),
      .step  (lfsr_step),
      .seed  (seed_i ^ LaneSeed),
      .state (lfsr_state[l])
    );
  end

  // Kept field = mant[22:Trunc], guard = mant[Trunc-1], sticky = mant[Trunc-2:0].
  function automatic logic [31:0] shape_elem(logic [31:0] s, mode_e mode, sign_mode_e smode,
                                             logic [ExpW-1:0] bexp, logic blk_lsb);
    logic            sgn;
    logic [ExpW-1:0] exp_f;
    logic [ManW-1:0] mant;
    mant  = s[ManW-1:0];
    exp_f = bexp;
    case (mode)
      ModeCarry: begin
        mant = mant | GuardBit | ManW'(1);
        if ((mant & KeepMask) == KeepMask) mant = mant & ~KeepLsb;
      end
      ModeTie:     mant = (mant & KeepMask) | GuardBit;
      ModeMantOvf: mant = mant | KeepMask | GuardBit | ManW'(1);
      ModeScaleOvf: begin
        mant  = mant | KeepMask | GuardBit | ManW'(1);
        exp_f = ScaleOvfExp;
      end
      ModeNan: begin
        exp_f          = NanExp;
        mant[ManW-1]   = 1'b1;
      end
      ModeSubnorm: begin
        exp_f   = '0;
        mant[0] = 1'b1;
      end
      default: exp_f = clamp_exp(s[30:23], NormExpMin, NormExpMax);
    endcase
    case (smode)
      SignPos: sgn = 1'b0;
      SignNeg: sgn = 1'b1;
      SignAlt: sgn = blk_lsb;
      default: sgn = s[31];
    endcase
    return {sgn, exp_f, mant};
  endfunction

  assign accept       = valid_q && ready_i;
  assign beat_is_last = (beat_q == BeatLast);
  assign final_beat   = beat_is_last && (blk_q == num_blocks_q - 16'd1);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    blk_d     = blk_q;
    blk_exp_d = blk_exp_q;
    valid_d   = valid_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    new_block = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StLoad;
          lfsr_load = 1'b1;
        end
      end
      StLoad: begin
        lfsr_step = 1'b1;
        beat_d    = '0;
        blk_d     = '0;
        new_block = 1'b1;
        if (num_blocks_q == 16'd0) begin
          state_d = StDone;
        end else begin
          state_d = StRun;
          valid_d = 1'b1;
        end
      end
      StRun: begin
        if (accept) begin
          lfsr_step = 1'b1;
          if (beat_is_last) begin
            beat_d    = '0;
            blk_d     = blk_q + 16'd1;
            new_block = 1'b1;
            if (final_beat) begin
              state_d = StDone;
              valid_d = 1'b0;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Lane 0 state at the first beat of a block also picks that block's shared exponent.
    if (new_block) blk_exp_d = clamp_exp(lfsr_state[0][7:0], BlkExpMin, BlkExpMax);
    // Abort wins over start and over a beat accepted in the same cycle.
    if (abort_i) begin
      state_d   = StIdle;
      valid_d   = 1'b0;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      beat_d    = beat_q;
      blk_d     = blk_q;
      blk_exp_d = blk_exp_q;
    end
  end

  always_comb begin
    data_d = data_q;
    if (lfsr_step) begin
      for (int l = 0; l < LANES; l++) begin
        data_d[32*l +: 32] = shape_elem(lfsr_state[l], mode_q, sign_q, blk_exp_d, blk_d[0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      mode_q       <= ModeNormal;
      sign_q       <= SignPos;
      num_blocks_q <= '0;
      beat_q       <= '0;
      blk_q        <= '0;
      blk_exp_q    <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      blk_q     <= blk_d;
      blk_exp_q <= blk_exp_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      if (lfsr_load) begin
        mode_q       <= mode_e'(mode_i);
        sign_q       <= sign_mode_e'(sign_mode_i);
        num_blocks_q <= num_blocks_i;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = valid_q && beat_is_last;
  assign busy_o  = (state_q == StLoad) || (state_q == StRun);
  assign done_o  = (state_q == StDone);

endmodule

// File: tb/tb_mx_fp32_stim_gen.sv
// Scoreboard bench for mx_fp32_stim_gen: expected beats come from a reference model built
// from LFSR sequences and field rules; a negedge monitor pops and compares on each accept.
`timescale 1ns/1ps
module tb_mx_fp32_stim_gen;

  localparam int LANES      = 4;
  localparam int BLOCK_SIZE = 32;
  localparam int ELEM_MBITS = 6;
  localparam int BPB        = BLOCK_SIZE / LANES;
  localparam int T          = 23 - ELEM_MBITS;

  localparam int M_NORMAL = 0, M_CARRY = 1, M_TIE = 2, M_MANT_OVF = 3;
  localparam int M_SCALE_OVF = 4, M_NAN = 5, M_SUBNORM = 6;
  localparam int S_POS = 0, S_NEG = 1, S_ALT = 2, S_RAND = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                start_i, abort_i, ready_i;
  logic [2:0]          mode_i;
  logic [1:0]          sign_mode_i;
  logic [15:0]         num_blocks_i;
  logic [31:0]         seed_i;
  logic [32*LANES-1:0] data_o;
  logic                valid_o, last_o, busy_o, done_o;

  mx_fp32_stim_gen #(
    .LANES      (LANES),
    .BLOCK_SIZE (BLOCK_SIZE),
    .ELEM_MBITS (ELEM_MBITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .mode_i       (mode_i),
    .sign_mode_i  (sign_mode_i),
    .num_blocks_i (num_blocks_i),
    .seed_i       (seed_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [32*LANES-1:0] data;
    logic                last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] lane0_log[$];
  int          last_beats[$];
  int          acc_cnt, done_cnt, done_cyc, last_acc_cyc;
  int          cur_mode, cur_sm;
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] lfsr_next(logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [31:0] ref_elem(logic [31:0] s, int mode, int sm, int bexp, int blk);
    int unsigned frac   = 32'(s[22:0]);
    int unsigned kmax   = (1 << ELEM_MBITS) - 1;
    int unsigned k      = frac >> T;
    int unsigned half   = 1 << (T - 1);
    int unsigned sticky = (frac % half) | 1;
    int unsigned e, m;
    bit sg;
    case (mode)
      M_CARRY: begin
        if (k == kmax) k = k - 1;
        e = bexp;
        m = (k << T) + half + sticky;
      end
      M_TIE:       begin e = bexp; m = (k << T) + half; end
      M_MANT_OVF:  begin e = bexp; m = (kmax << T) + half + sticky; end
      M_SCALE_OVF: begin e = 254;  m = (kmax << T) + half + sticky; end
      M_NAN:       begin e = 255;  m = frac | (1 << 22); end
      M_SUBNORM:   begin e = 0;    m = frac | 1; end
      default: begin
        e = 32'(s[30:23]);
        if (e == 0) e = 1;
        if (e == 255) e = 254;
        m = frac;
      end
    endcase
    case (sm)
      S_POS:   sg = 1'b0;
      S_NEG:   sg = 1'b1;
      S_ALT:   sg = blk[0];
      default: sg = s[31];
    endcase
    return {sg, e[7:0], m[22:0]};
  endfunction

  // MXINT8 shared-scale exponent after round-to-nearest-even of one element; 255 = NaN scale.
  function automatic int mx_scale_exp(logic [31:0] el);
    int unsigned frac = 32'(el[22:0]);
    int unsigned k    = frac >> T;
    int unsigned g    = (frac >> (T - 1)) & 1;
    int unsigned st   = frac % (1 << (T - 1));
    int unsigned up   = (g == 1 && (st != 0 || (k & 1) == 1)) ? 1 : 0;
    int ex = int'(el[30:23]);
    if (k + up == (1 << ELEM_MBITS)) ex = ex + 1;
    return ex;
  endfunction

  task automatic push_run(input int mode, input int sm, input int nb, input logic [31:0] seed);
    logic [31:0] st[LANES];
    int bexp;
    beat_t bt;
    for (int l = 0; l < LANES; l++) begin
      st[l] = seed ^ (32'(l) * 32'h9E37_79B9);
      if (st[l] == 32'd0) st[l] = 32'd1;
    end
    for (int b = 0; b < nb; b++) begin
      bexp = int'(st[0] & 32'hFF);
      if (bexp < 2) bexp = 2;
      if (bexp > 253) bexp = 253;
      for (int k = 0; k < BPB; k++) begin
        for (int l = 0; l < LANES; l++) begin
          bt.data[32*l +: 32] = ref_elem(st[l], mode, sm, bexp, b);
          st[l] = lfsr_next(st[l]);
        end
        bt.last = (k == BPB - 1);
        exp_q.push_back(bt);
      end
    end
  endtask

  // ---------------- clock counter, ready driver ----------------
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [32*LANES-1:0] prev_data;
    bit                  prev_stall;
    beat_t               bt;
    logic [31:0]         el;
    int                  blk;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", 128'(valid_o), 128'(1));
          check("stall_data_held", data_o, prev_data);
        end
        prev_stall = valid_o && !ready_i && !abort_i;
        prev_data  = data_o;
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (valid_o && ready_i && !abort_i) begin
          acc_cnt++;
          last_acc_cyc = cyc;
          if (last_o) last_beats.push_back(acc_cnt);
          lane0_log.push_back(data_o[31:0]);
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 128'(1), 128'(0));
          end else begin
            bt = exp_q.pop_front();
            check("beat_data", data_o, bt.data);
            check("beat_last", 128'(last_o), 128'(bt.last));
          end
          blk = (acc_cnt - 1) / BPB;
          for (int l = 0; l < LANES; l++) begin
            el = data_o[32*l +: 32];
            if (cur_mode == M_NORMAL)
              check("normal_exp_in_range", 128'(el[30:23] >= 1 && el[30:23] <= 254), 128'(1));
            if (cur_sm == S_POS) check("pos_sign", 128'(el[31]), 128'(0));
            if (cur_sm == S_ALT) check("alt_sign", 128'(el[31]), 128'(blk & 1));
            if (cur_mode == M_TIE) begin
              check("tie_guard", 128'(el[16]), 128'(1));
              check("tie_sticky_zero", 128'(el[15:0]), 128'(0));
            end
            if (cur_mode == M_SCALE_OVF) begin
              check("scale_ovf_exp", 128'(el[30:23]), 128'(8'hFE));
              check("scale_ovf_kept_ones", 128'(el[22:16]), 128'(7'h7F));
              check("scale_ovf_mx_nan", 128'(mx_scale_exp(el)), 128'(255));
            end
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int mode, input int sm, input int nb, input logic [31:0] seed);
    cur_mode     = mode;
    cur_sm       = sm;
    acc_cnt      = 0;
    done_cnt     = 0;
    done_cyc     = -1;
    last_acc_cyc = -1;
    last_beats.delete();
    lane0_log.delete();
    exp_q.delete();
    push_run(mode, sm, nb, seed);
    mode_i       = 3'(mode);
    sign_mode_i  = 2'(sm);
    num_blocks_i = 16'(nb);
    seed_i       = seed;
    start_i      = 1'b1;
    tick();
    start_i      = 1'b0;
    check("load_busy", 128'(busy_o), 128'(1));
    check("load_no_valid", 128'(valid_o), 128'(0));
    tick();
    check("run_valid_t2", 128'(valid_o), 128'(nb != 0));
  endtask

  task automatic finish_run(input int nb);
    int i;
    for (i = 0; i < 4000 && done_cnt == 0; i++) tick();
    check("done_seen", 128'(done_cnt > 0), 128'(1));
    repeat (3) tick();
    check("done_single_pulse", 128'(done_cnt), 128'(1));
    check("beat_count", 128'(acc_cnt), 128'(nb * BPB));
    check("queue_drained", 128'(exp_q.size()), 128'(0));
    check("idle_after_done", 128'(busy_o), 128'(0));
    if (nb > 0) check("done_latency", 128'(done_cyc), 128'(last_acc_cyc + 1));
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 400 && acc_cnt < n; i++) tick();
    check("reach_beat", 128'(acc_cnt), 128'(n));
  endtask

  initial begin : stim
    logic [31:0] seed;
    logic [31:0] log0[$];
    int          nb;
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    mode_i = '0; sign_mode_i = '0; num_blocks_i = '0; seed_i = '0;
    repeat (3) tick();
    check("rst_data", data_o, '0);
    check("rst_valid", 128'(valid_o), 128'(0));
    check("rst_last", 128'(last_o), 128'(0));
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_done", 128'(done_o), 128'(0));
    start_i = 1'b1;
    num_blocks_i = 16'd1;
    tick();
    check("rst_overrides_start", 128'(busy_o), 128'(0));
    start_i = 1'b0;
    rst = 1'b0;
    tick();

    // NORMAL / POS, two blocks
    start_run(M_NORMAL, S_POS, 2, $urandom);
    finish_run(2);
    check("last_count", 128'(last_beats.size()), 128'(2));
    if (last_beats.size() == 2) begin
      check("last_beat_a", 128'(last_beats[0]), 128'(8));
      check("last_beat_b", 128'(last_beats[1]), 128'(16));
    end

    start_run(M_TIE, S_ALT, 2, $urandom);
    finish_run(2);
    start_run(M_SCALE_OVF, S_POS, 1, $urandom);
    finish_run(1);

    // Same seed with 50% ready and with ready held high
    seed = $urandom;
    rand_ready = 1'b1;
    start_run(M_CARRY, S_RAND, 3, seed);
    finish_run(3);
    rand_ready = 1'b0;
    tick();
    start_run(M_CARRY, S_RAND, 3, seed);
    finish_run(3);

    // seed 0 must behave as seed 1 on lane 0
    start_run(M_NORMAL, S_RAND, 1, 32'd0);
    finish_run(1);
    log0 = lane0_log;
    start_run(M_NORMAL, S_RAND, 1, 32'd1);
    finish_run(1);
    check("seed0_log_len", 128'(lane0_log.size()), 128'(log0.size()));
    for (int i = 0; i < log0.size() && i < lane0_log.size(); i++)
      check("seed0_eq_seed1_lane0", 128'(log0[i]), 128'(lane0_log[i]));

    // Zero blocks: LOAD then DONE with no beats
    start_run(M_NORMAL, S_POS, 0, $urandom);
    finish_run(0);

    // Abort at beat 5
    start_run(M_MANT_OVF, S_NEG, 2, $urandom);
    wait_beats(5);
    abort_i = 1'b1;
    exp_q.delete();
    tick();
    abort_i = 1'b0;
    check("abort_valid_low", 128'(valid_o), 128'(0));
    check("abort_idle", 128'(busy_o), 128'(0));
    repeat (3) tick();
    check("abort_no_done", 128'(done_cnt), 128'(0));
    check("abort_beats", 128'(acc_cnt), 128'(5));

    // Reset at beat 3
    start_run(M_NAN, S_ALT, 2, $urandom);
    wait_beats(3);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("midrst_valid_low", 128'(valid_o), 128'(0));
    check("midrst_data_zero", data_o, '0);
    check("midrst_idle", 128'(busy_o), 128'(0));
    rst = 1'b0;
    repeat (3) tick();
    check("midrst_no_done", 128'(done_cnt), 128'(0));

    // Fresh run after abort/reset
    start_run(M_SUBNORM, S_RAND, 2, $urandom);
    finish_run(2);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      rand_ready = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      start_run($urandom_range(0, 6), $urandom_range(0, 3), nb, $urandom);
      finish_run(nb);
    end
    rand_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

endmodule
